seq_comp_n: RTL
===============

# seq_comp_n

Parametrised multi-cycle magnitude comparator, the sequential successor to the 8-bit cascadable comparator. Compares two WIDTH-bit operands one SLICE-bit slice per clock, most-significant slice first, and terminates early on the first unequal slice. Supports unsigned and two's-complement modes and keeps the EQ/GT cascade inputs so that units can be chained for wider compares. Sits on the lab datapath wherever a wide compare must share one narrow slice comparator across cycles.

## Interface
- WIDTH, 32, operand width; must be an integer multiple of SLICE.
- SLICE, 8, bits compared per cycle; NSLICE = WIDTH/SLICE, with NSLICE ≥ 1.
- clk  input  1  single clock; every register updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- start  input  1  request a compare; accepted only while idle.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled on the accepting edge.
- EQ1  input  1  cascade equal-in from a lower-significance stage; sampled on the accepting edge.
- GT1  input  1  cascade greater-in from a lower-significance stage; sampled on the accepting edge.
- EQ  output  1  registered result, A == B.
- GT  output  1  registered result, A > B.
- LT  output  1  registered result, A < B.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse marking a valid result.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: steps through slices.
- IDLE → RUN: start=1 on an edge while in IDLE.
  - Latch A, B, sgn, EQ1 and GT1.
  - Set slice index k = NSLICE-1.
  - Set busy=1.
- RUN, each edge: compare slices A[k*SLICE +: SLICE] and B[k*SLICE +: SLICE].
  - The top slice (k = NSLICE-1) is compared as signed when sgn=1.
  - All other slices are always compared as unsigned.
  - Slices unequal: load GT/LT from this slice, set EQ=0, pulse done, clear busy, go to IDLE.
  - Slices equal and k > 0: decrement k and stay in RUN.
  - Slices equal and k = 0: resolve from the cascade inputs, pulse done, clear busy, go to IDLE.
- Cascade resolution:
  - EQ = EQ1.
  - GT = ~EQ1 & GT1.
  - LT = ~EQ1 & ~GT1.
  - With EQ1=1 the unit behaves as a plain standalone comparator.
- Results:
  - EQ, GT and LT are one-hot whenever done=1.
  - They hold their value after done until the next compare completes.
- start while busy=1 is ignored: not queued, and the latched operands do not change.
- start on the same edge that completes a compare is ignored, because the state is still RUN on that edge.
- Input changes on A, B, sgn, EQ1 or GT1 after acceptance have no effect on the compare in progress.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, busy=0, done=0.
  - EQ=1, GT=0, LT=0.
  - k=NSLICE-1.
  - Reset overrides start on the same edge.
- Reset during RUN aborts the compare: no done pulse, and outputs go to their reset values on that edge.
- Latency: with the request accepted at edge 0, done=1 is registered at edge m, where m is the number of slices examined (1 ≤ m ≤ NSLICE).
  - Worst case, fully equal operands: m = NSLICE.
- busy is high from edge 0 through edge m-1 and low from edge m onward.
- done is high for exactly one cycle, following edge m.
- The earliest next accepted start is at edge m+1, giving a back-to-back throughput of one compare per m+1 cycles.
- NSLICE=1: the compare is always a single cycle.

## Test plan
- Reset hold: rst_n=0 for 2 cycles with start=1 → EQ=1, GT=0, LT=0, busy=0, done=0 throughout.
- Late difference, WIDTH=32, SLICE=8, sgn=0: A=0x12345678, B=0x12345677 → done at edge 4, GT=1, EQ=0, LT=0.
- Signed versus unsigned, A=0x80000000, B=0x7FFFFFFF:
  - sgn=0 → done at edge 1 with GT=1.
  - sgn=1 → done at edge 1 with LT=1.
- Cascade, A=B=0xDEADBEEF:
  - EQ1=1 → EQ=1 at edge 4.
  - EQ1=0, GT1=1 → GT=1.
  - EQ1=0, GT1=0 → LT=1.
- Busy and abort:
  - start pulsed at edge 2 during an equal-operand compare → ignored; done only at edge 4; result matches the first operands.
  - rst_n=0 at edge 2 → no done pulse, outputs return to reset values.
- Sweep: for i = 1000..1999, apply {GT1, A[7:0], B[7:0]} = i[16:0] with WIDTH=8, SLICE=4, EQ1=1 → each result matches a reference magnitude compare.

Source files
------------

// File: rtl/seq_comp_n.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands one SLICE-bit slice
// per clock, MSB slice first, stopping early at the first unequal slice.
module seq_comp_n #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  input  logic             EQ1,
  input  logic             GT1,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KMAX = KW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             eq1_q;
  logic             gt1_q;

  logic             accept;
  logic             top_slice;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic             slice_eq;
  logic             slice_gt;

  assign accept    = (state == IDLE) && start;
  assign top_slice = sgn_q && (k == KMAX);

  // Operands shift left each RUN cycle, so the slice under test is always the
  // top SLICE bits; a signed top slice compares unsigned once its MSBs are flipped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sa = a_q[WIDTH-1 -: SLICE];
    sb = b_q[WIDTH-1 -: SLICE];
    if (top_slice) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
  end

  assign slice_eq = (sa == sb);
  assign slice_gt = (sa > sb);

  // NOTE: operand registers carry no reset; they are only read while RUN, which
  // is entered solely through a load, so resetting them would only cost muxes.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= A;
      b_q   <= B;
      sgn_q <= sgn;
      eq1_q <= EQ1;
      gt1_q <= GT1;
    end else if (state == RUN) begin
      a_q <= a_q << SLICE;
      b_q <= b_q << SLICE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      EQ    <= 1'b1;
      GT    <= 1'b0;
      LT    <= 1'b0;
      k     <= KMAX;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            k     <= KMAX;
          end
        end
        RUN: begin
          if (!slice_eq) begin
            EQ    <= 1'b0;
            GT    <= slice_gt;
            LT    <= ~slice_gt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (k != '0) begin
            k <= k - KW'(1);
          end else begin
            // All slices equal: the lower-significance stage decides.
            EQ    <= eq1_q;
            GT    <= ~eq1_q & gt1_q;
            LT    <= ~eq1_q & ~gt1_q;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
